lsu_ctrl: RTL and testbench

Parametrised, multi-cycle load/store controller between the control unit and data memory. It takes one load or store request at a time, computes the effective address, and runs the memory handshake. For loads it performs byte/half/word/double extraction with sign or zero extension. For stores it either merges sub-word data by read-modify-write or drives byte enables. It also detects misaligned accesses and reports them instead of touching memory.

---
 rtl/lsu_ctrl.sv | 171 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store controller: effective address, alignment check, memory
// handshake, load extraction/extension and sub-word store merge or byte enables.
module lsu_ctrl #(
    parameter int XLEN      = 32,
    parameter int ADDR_W    = 32,
    parameter int RMW_STORE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_load,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [XLEN-1:0]     req_base,
    input  logic [XLEN-1:0]     req_offset,
    input  logic [XLEN-1:0]     req_wdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_rd_en,
    output logic                mem_wr_en,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_be,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic                mem_ack,
    output logic                resp_valid,
    output logic [XLEN-1:0]     resp_data,
    output logic                resp_misalign
);
    localparam int NB = XLEN / 8;
    localparam int LW = $clog2(NB);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    typedef struct packed {
        logic       load;
        logic [1:0] size;
        logic       uns;
        logic [2:0] ea_lo;
    } req_t;

    state_t state, state_nx;
    req_t   r;

    function automatic logic [NB-1:0] byte_mask(input logic [1:0] size, input logic [LW-1:0] lane);
        logic [NB-1:0] m;
        m = NB'((32'd1 << (32'd1 << size)) - 32'd1);
        return m << lane;
    endfunction

    function automatic logic [XLEN-1:0] replicate(input logic [1:0] size, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] o;
        int n;
        n = 1 << size;
        for (int i = 0; i < NB; i++) o[i*8 +: 8] = d[(i % n)*8 +: 8];
        return o;
    endfunction

    logic [XLEN-1:0]   sum_in;
    logic [ADDR_W-1:0] ea_in;
    logic [NB-1:0]     mask_in, mask_r;
    logic              rmw_in, misalign;
    logic [LW-1:0]     lane_r;
    logic [XLEN-1:0]   load_val, merged, bit_mask;

    assign sum_in    = req_base + req_offset;
    assign ea_in     = ADDR_W'(sum_in);
    assign mask_in   = byte_mask(req_size, ea_in[LW-1:0]);
    assign rmw_in    = (RMW_STORE != 0) && !req_load && ((8 << req_size) < XLEN);
    assign req_ready = (state == IDLE);
    assign lane_r    = r.ea_lo[LW-1:0];
    assign mask_r    = byte_mask(r.size, lane_r);

    always_comb begin
        case (r.size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = r.ea_lo[0];
            2'b10:   misalign = |r.ea_lo[1:0];
            default: misalign = (XLEN == 32) || (|r.ea_lo);
        endcase
    end

    // Shift the addressed lane down, keep its width, fill above with sign or zero.
    always_comb begin
        logic [XLEN-1:0] sh, keep;
        int nbits;
        logic sgn;
        sh    = mem_rdata >> {lane_r, 3'b000};
        nbits = 8 << r.size;
        if (nbits > XLEN) nbits = XLEN;
        for (int i = 0; i < XLEN; i++) keep[i] = (i < nbits);
        sgn      = ~r.uns & sh[nbits-1];
        load_val = (sh & keep) | ({XLEN{sgn}} & ~keep);
    end

    // For RMW stores mem_wdata already holds the replicated store data.
    always_comb begin
        for (int i = 0; i < NB; i++) bit_mask[i*8 +: 8] = {8{mask_r[i]}};
        merged = (mem_rdata & ~bit_mask) | (mem_wdata & bit_mask);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Alignment is judged on the registered address during the first cycle of
    // READ/WRITE, before any enable rises, so a rejected access never reaches memory.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (req_valid) state_nx = (req_load || rmw_in) ? READ : WRITE;
            READ:  if (!mem_rd_en) begin
                       if (misalign) state_nx = RESP;
                   end else if (mem_ack) begin
                       state_nx = r.load ? RESP : WRITE;
                   end
            WRITE: if (!mem_wr_en) begin
                       if (misalign) state_nx = RESP;
                   end else if (mem_ack) begin
                       state_nx = RESP;
                   end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r             <= '0;
            mem_addr      <= '0;
            mem_rd_en     <= 1'b0;
            mem_wr_en     <= 1'b0;
            mem_wdata     <= '0;
            mem_be        <= '0;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            resp_misalign <= 1'b0;
        end else begin
            resp_valid <= (state_nx == RESP);
            case (state)
                IDLE: if (req_valid) begin
                    r.load        <= req_load;
                    r.size        <= req_size;
                    r.uns         <= req_unsigned;
                    r.ea_lo       <= ea_in[2:0];
                    mem_addr      <= {ea_in[ADDR_W-1:LW], {LW{1'b0}}};
                    mem_be        <= rmw_in ? '1 : mask_in;
                    mem_wdata     <= req_load ? '0 : replicate(req_size, req_wdata);
                    resp_data     <= '0;
                    resp_misalign <= 1'b0;
                end
                READ: if (!mem_rd_en) begin
                    if (misalign) resp_misalign <= 1'b1;
                    else          mem_rd_en     <= 1'b1;
                end else if (mem_ack) begin
                    mem_rd_en <= 1'b0;
                    if (r.load) resp_data <= load_val;
                    else        mem_wdata <= merged;
                end
                WRITE: if (!mem_wr_en) begin
                    if (misalign) resp_misalign <= 1'b1;
                    else          mem_wr_en     <= 1'b1;
                end else if (mem_ack) begin
                    mem_wr_en <= 1'b0;
                end
                RESP:    resp_misalign <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: three configurations (32/RMW, 32/byte-enable, 64/RMW) against
// a byte-addressed reference memory model, directed cases then random traffic.
module tb_lsu_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]        rv = '0;
    logic [2:0]        rdy, rd_en, wr_en, rsp_v, rsp_mis;
    logic [2:0]        ack = '0;
    logic              req_load = 1'b0, req_uns = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic [63:0]       base = '0, off = '0, wdat = '0;
    logic [2:0][31:0]  addr;
    logic [2:0][63:0]  wd, rsp_d;
    logic [2:0][63:0]  rdat = '0;
    logic [2:0][7:0]   be;

    assign wd[0][63:32]    = '0;
    assign wd[1][63:32]    = '0;
    assign be[0][7:4]      = '0;
    assign be[1][7:4]      = '0;
    assign rsp_d[0][63:32] = '0;
    assign rsp_d[1][63:32] = '0;

    lsu_ctrl #(.XLEN(32), .ADDR_W(32), .RMW_STORE(1)) u0 (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rdy[0]), .req_load(req_load),
        .req_size(req_size), .req_unsigned(req_uns), .req_base(base[31:0]), .req_offset(off[31:0]),
        .req_wdata(wdat[31:0]), .mem_addr(addr[0]), .mem_rd_en(rd_en[0]), .mem_wr_en(wr_en[0]),
        .mem_wdata(wd[0][31:0]), .mem_be(be[0][3:0]), .mem_rdata(rdat[0][31:0]), .mem_ack(ack[0]),
        .resp_valid(rsp_v[0]), .resp_data(rsp_d[0][31:0]), .resp_misalign(rsp_mis[0]));

    lsu_ctrl #(.XLEN(32), .ADDR_W(32), .RMW_STORE(0)) u1 (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rdy[1]), .req_load(req_load),
        .req_size(req_size), .req_unsigned(req_uns), .req_base(base[31:0]), .req_offset(off[31:0]),
        .req_wdata(wdat[31:0]), .mem_addr(addr[1]), .mem_rd_en(rd_en[1]), .mem_wr_en(wr_en[1]),
        .mem_wdata(wd[1][31:0]), .mem_be(be[1][3:0]), .mem_rdata(rdat[1][31:0]), .mem_ack(ack[1]),
        .resp_valid(rsp_v[1]), .resp_data(rsp_d[1][31:0]), .resp_misalign(rsp_mis[1]));

    lsu_ctrl #(.XLEN(64), .ADDR_W(32), .RMW_STORE(1)) u2 (
        .clk(clk), .rst(rst), .req_valid(rv[2]), .req_ready(rdy[2]), .req_load(req_load),
        .req_size(req_size), .req_unsigned(req_uns), .req_base(base), .req_offset(off),
        .req_wdata(wdat), .mem_addr(addr[2]), .mem_rd_en(rd_en[2]), .mem_wr_en(wr_en[2]),
        .mem_wdata(wd[2]), .mem_be(be[2]), .mem_rdata(rdat[2]), .mem_ack(ack[2]),
        .resp_valid(rsp_v[2]), .resp_data(rsp_d[2]), .resp_misalign(rsp_mis[2]));

    function automatic int nbytes(input int k);
        return (k == 2) ? 8 : 4;
    endfunction

    function automatic logic [7:0] init_byte(input int k, input int a);
        return 8'((a * 7) + (k * 13) + 1);
    endfunction

    // Memory responder: acks after ack_delay wait cycles; owns the memory image.
    logic [7:0]       mem     [3][512];
    logic [7:0]       ref_mem [3][512];
    int               ack_delay = 0;
    int               cnt [3] = '{0, 0, 0};
    logic             mem_init = 1'b0;
    logic [2:0][63:0] last_wd   = '0;
    logic [2:0][7:0]  last_be   = '0;
    logic [2:0][31:0] last_addr = '0;

    always @(negedge clk) begin
        if (!mem_init) begin
            for (int k = 0; k < 3; k++)
                for (int a = 0; a < 512; a++) mem[k][a] = init_byte(k, a);
            mem_init = 1'b1;
        end
        for (int k = 0; k < 3; k++) begin
            if ((rd_en[k] || wr_en[k]) && !ack[k]) begin
                if (cnt[k] >= ack_delay) begin
                    ack[k] = 1'b1;
                    for (int i = 0; i < nbytes(k); i++) begin
                        if (rd_en[k]) rdat[k][i*8 +: 8] = mem[k][(addr[k] + 32'(i)) & 32'd511];
                        if (wr_en[k] && be[k][i]) mem[k][(addr[k] + 32'(i)) & 32'd511] = wd[k][i*8 +: 8];
                    end
                    if (wr_en[k]) begin
                        last_wd[k]   = wd[k];
                        last_be[k]   = be[k];
                        last_addr[k] = addr[k];
                    end
                end else begin
                    cnt[k]++;
                end
            end else begin
                ack[k] = 1'b0;
                cnt[k] = 0;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request on instance k, checked against the byte-level reference model.
    task automatic do_req(input int k, input logic ld, input logic [1:0] sz, input logic u,
                          input logic [63:0] b, input logic [63:0] o, input logic [63:0] w,
                          output logic [63:0] data_o);
        int n, nb, lat, exp_rd, exp_wr, cyc, rdc, wrc, unst;
        logic [31:0] ea, wa, a0;
        logic mis, rmw, got;
        logic [63:0] exp_d, wd0, obsm, expm;
        logic [7:0] be0;
        nb  = nbytes(k);
        n   = 1 << sz;
        ea  = b[31:0] + o[31:0];
        mis = (n > nb) || ((ea % n) != 0);
        rmw = !ld && (k != 1) && (n < nb);
        exp_d = '0;
        if (ld && !mis) begin
            for (int i = 0; i < n; i++) exp_d[i*8 +: 8] = ref_mem[k][(ea + 32'(i)) & 32'd511];
            if (!u && exp_d[8*n-1]) for (int i = 8*n; i < 64; i++) exp_d[i] = 1'b1;
            if (nb == 4) exp_d[63:32] = '0;
        end
        if (!ld && !mis)
            for (int i = 0; i < n; i++) ref_mem[k][(ea + 32'(i)) & 32'd511] = w[i*8 +: 8];
        lat    = mis ? 2 : (rmw ? 5 + 2*ack_delay : 3 + ack_delay);
        exp_rd = (!mis && (ld || rmw)) ? 1 + ack_delay : 0;
        exp_wr = (!mis && !ld) ? 1 + ack_delay : 0;

        @(negedge clk);
        req_load = ld; req_size = sz; req_uns = u; base = b; off = o; wdat = w;
        rv[k] = 1'b1;
        chk($sformatf("ready k%0d", k), 64'(rdy[k]), 64'd1);
        @(posedge clk);
        #1 rv[k] = 1'b0;
        cyc = 0; rdc = 0; wrc = 0; unst = 0; got = 1'b0;
        wd0 = '0; a0 = '0; be0 = '0;
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (rd_en[k]) rdc++;
            if (wr_en[k]) begin
                if (wrc > 0 && (wd[k] !== wd0 || addr[k] !== a0 || be[k] !== be0)) unst++;
                wd0 = wd[k]; a0 = addr[k]; be0 = be[k];
                wrc++;
            end
            if (rsp_v[k]) got = 1'b1;
        end
        data_o = rsp_d[k];
        chk($sformatf("resp_seen k%0d", k), 64'(got), 64'd1);
        chk($sformatf("latency k%0d", k), 64'(cyc), 64'(lat));
        chk($sformatf("misalign k%0d", k), 64'(rsp_mis[k]), 64'(mis));
        chk($sformatf("resp_data k%0d", k), rsp_d[k], exp_d);
        chk($sformatf("rd_cycles k%0d", k), 64'(rdc), 64'(exp_rd));
        chk($sformatf("wr_cycles k%0d", k), 64'(wrc), 64'(exp_wr));
        chk($sformatf("wr_stable k%0d", k), 64'(unst), 64'd0);
        if (!ld) begin
            wa = ea & ~32'(nb - 1);
            obsm = '0; expm = '0;
            for (int i = 0; i < nb; i++) begin
                obsm[i*8 +: 8] = mem[k][(wa + 32'(i)) & 32'd511];
                expm[i*8 +: 8] = ref_mem[k][(wa + 32'(i)) & 32'd511];
            end
            chk($sformatf("mem_word k%0d", k), obsm, expm);
        end
        @(negedge clk);
        chk($sformatf("resp_pulse k%0d", k), 64'(rsp_v[k]), 64'd0);
    endtask

    initial begin
        logic [63:0] d;
        int k, waited;
        logic seen;
        for (int kk = 0; kk < 3; kk++)
            for (int a = 0; a < 512; a++) ref_mem[kk][a] = init_byte(kk, a);

        // Reset values
        #2;
        for (int kk = 0; kk < 3; kk++) begin
            chk("rst_ready", 64'(rdy[kk]), 64'd1);
            chk("rst_en", {62'd0, rd_en[kk], wr_en[kk]}, 64'd0);
            chk("rst_addr", 64'(addr[kk]), 64'd0);
            chk("rst_wdata", wd[kk], 64'd0);
            chk("rst_be", 64'(be[kk]), 64'd0);
            chk("rst_resp", {62'd0, rsp_v[kk], rsp_mis[kk]}, 64'd0);
            chk("rst_rdata", rsp_d[kk], 64'd0);
        end
        @(negedge clk); rst = 1'b1;

        // Reset in the middle of a read
        ack_delay = 10;
        @(negedge clk);
        req_load = 1'b1; req_size = 2'b10; req_uns = 1'b0; base = 64'h100; off = '0;
        rv[0] = 1'b1;
        @(posedge clk); #1 rv[0] = 1'b0;
        waited = 0;
        while (!rd_en[0] && waited < 5) begin @(negedge clk); waited++; end
        chk("midrd_en_seen", 64'(rd_en[0]), 64'd1);
        #2 rst = 1'b0;
        #1 chk("midrd_en_drop", 64'(rd_en[0]), 64'd0);
        chk("midrd_ready", 64'(rdy[0]), 64'd1);
        @(negedge clk); rst = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin @(negedge clk); if (rsp_v[0]) seen = 1'b1; end
        chk("midrd_no_resp", 64'(seen), 64'd0);
        ack_delay = 0;

        // Loads from 0x80FF7F01
        do_req(0, 1'b0, 2'b10, 1'b0, 64'h100, 64'd0, 64'h80FF7F01, d);
        do_req(1, 1'b0, 2'b10, 1'b0, 64'h100, 64'd0, 64'h80FF7F01, d);
        do_req(0, 1'b1, 2'b00, 1'b0, 64'h100, 64'd3, 64'd0, d);
        chk("lb", d, 64'hFFFFFF80);
        do_req(0, 1'b1, 2'b00, 1'b1, 64'h100, 64'd3, 64'd0, d);
        chk("lbu", d, 64'h00000080);
        do_req(0, 1'b1, 2'b01, 1'b0, 64'h100, 64'd2, 64'd0, d);
        chk("lh", d, 64'hFFFF80FF);

        // Sub-word stores
        do_req(0, 1'b0, 2'b10, 1'b0, 64'h100, 64'd0, 64'h11223344, d);
        do_req(0, 1'b0, 2'b00, 1'b0, 64'h100, 64'd1, 64'h000000AB, d);
        chk("rmw_wdata", last_wd[0], 64'h1122AB44);
        chk("rmw_be", 64'(last_be[0]), 64'hF);
        do_req(1, 1'b0, 2'b01, 1'b0, 64'h100, 64'd2, 64'h0000BEEF, d);
        chk("sh_wdata", last_wd[1], 64'hBEEFBEEF);
        chk("sh_be", 64'(last_be[1]), 64'hC);

        // Misaligned
        do_req(0, 1'b1, 2'b10, 1'b0, 64'h100, 64'd2, 64'd0, d);
        do_req(0, 1'b1, 2'b01, 1'b0, 64'h100, 64'd1, 64'd0, d);
        do_req(0, 1'b1, 2'b11, 1'b0, 64'h100, 64'd0, 64'd0, d);
        do_req(1, 1'b0, 2'b10, 1'b0, 64'h100, 64'd1, 64'h12345678, d);

        // Wrap-around address with wait states
        ack_delay = 4;
        do_req(0, 1'b0, 2'b10, 1'b0, 64'hFFFFFFFC, 64'd8, 64'hCAFEF00D, d);
        chk("wrap_addr", 64'(last_addr[0]), 64'h4);
        ack_delay = 0;

        // 64-bit datapath
        do_req(2, 1'b0, 2'b11, 1'b0, 64'h08, 64'd0, 64'h8877665544332211, d);
        do_req(2, 1'b1, 2'b11, 1'b0, 64'h08, 64'd0, 64'd0, d);
        chk("ld64", d, 64'h8877665544332211);
        do_req(2, 1'b1, 2'b10, 1'b0, 64'h08, 64'd4, 64'd0, d);
        chk("lw64_sext", d, 64'hFFFFFFFF88776655);
        do_req(2, 1'b1, 2'b11, 1'b0, 64'h04, 64'd0, 64'd0, d);
        chk("ld64_misalign_data", d, 64'd0);

        // Random traffic
        for (int t = 0; t < 60; t++) begin
            logic [1:0] sz;
            logic [63:0] b, o;
            k  = int'($urandom_range(0, 2));
            sz = 2'($urandom_range(0, 3));
            b  = 64'($urandom_range(0, 63) * 8);
            o  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 7))
                                             : 64'((1 << sz) * $urandom_range(0, 1));
            ack_delay = int'($urandom_range(0, 2));
            do_req(k, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), b, o,
                   {$urandom, $urandom}, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
